pipe_stage_ctrl: RTL and testbench

- Parametrised pipeline sequencing controller for the MIPS core family. It generates the per-stage enable, bubble/flush (rst) and valid signals for an N-stage in-order pipeline. The five-stage core's hand-wired if/id/exe/mem/wb scheme becomes one configurable block.
- New capabilities: arbitrary stage count, a configurable exception-commit stage, a drain/halt mode for cache or MMU maintenance, and a synchronised single-step debug mode.
- Sits between the stall sources (IMMU/ICACHE, hazard unit, DMMU/DCACHE) and the datapath pipeline registers.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_stage_ctrl_if.sv | 30 +++
 rtl/edge_sync.sv | 32 +++
 rtl/pipe_stage_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM state
// encodings, legal stage-count limits and the five-stage core defaults.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2,
    ST_STEP  = 2'd3
  } pipe_state_e;

  localparam int STAGES_MIN      = 2;
  localparam int STAGES_MAX      = 16;
  localparam int STAGES_5CORE    = 5;
  localparam int EXC_STAGE_5CORE = 3;

endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// Bundle between the pipeline controller, its stall/flush sources and the
// datapath pipeline registers. The controller uses the master view.
interface pipe_stage_ctrl_if #(
  parameter int STAGES = 5
) ();

  logic [STAGES-1:0] stall_req;
  logic              exc_flush;
  logic              br_flush;
  logic              drain_req;
  logic              debug_en;
  logic              debug_step;
  logic [STAGES-1:0] stage_en;
  logic [STAGES-1:0] stage_rst;
  logic [STAGES-1:0] stage_valid;
  logic              fetch_en;
  logic              drained;
  logic [1:0]        state;

  modport master (
    input  stall_req, exc_flush, br_flush, drain_req, debug_en, debug_step,
    output stage_en, stage_rst, stage_valid, fetch_en, drained, state
  );

  modport slave (
    output stall_req, exc_flush, br_flush, drain_req, debug_en, debug_step,
    input  stage_en, stage_rst, stage_valid, fetch_en, drained, state
  );

endinterface

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for an asynchronous input followed by a rising-edge
// detector; emits a one-cycle pulse per synchronised 0->1 transition.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  // sync_q[0] is the first capture flop; the extra top bit remembers the
  // previous synchronised value for edge detection.
  logic [SYNC_STAGES:0] sync_q, sync_d;

  // Shift the raw input into the synchroniser chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-1:0], din};
  end

  // Synchroniser and edge-history flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline sequencing controller: per-stage load enables, bubble/flush clears
// and valid tracking for an N-stage in-order pipeline, with drain/halt and
// synchronised single-step debug modes.
module pipe_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int STAGES      = STAGES_5CORE,
  parameter int EXC_STAGE   = EXC_STAGE_5CORE,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  pipe_stage_ctrl_if.master bus
);

  pipe_state_e       state_q, state_d;
  logic [STAGES-1:0] valid_q, valid_d;
  logic              pend_q, pend_d;

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] en_raw;
  logic [STAGES-1:0] rst_raw;
  logic              step_pulse;
  logic              step_fire;
  logic              tick;
  logic              fetch_raw;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_step_sync (
    .clk  (clk),
    .rst_n(rst),
    .din  (bus.debug_step),
    .pulse(step_pulse)
  );

  // A stall request at stage i holds that stage and everything upstream
  always_comb begin : hold_chain
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc     = acc | bus.stall_req[i];
      hold[i] = acc;
    end
  end

  // Advance tick, single-step consumption (one pending step max) and fetch gating
  always_comb begin
    step_fire = (state_q == ST_STEP) & (step_pulse | pend_q) & ~hold[0];
    tick      = (state_q == ST_RUN) | (state_q == ST_DRAIN) | step_fire;
    fetch_raw = ((state_q == ST_RUN) | (state_q == ST_STEP)) & ~bus.drain_req;
    pend_d    = pend_q;
    if (state_q != ST_STEP) begin
      pend_d = 1'b0;
    end else if (step_fire) begin
      pend_d = 1'b0;
    end else if (step_pulse & hold[0]) begin
      pend_d = 1'b1;
    end
  end

  // Enables, bubbles at the stall boundary, and flushes (flush beats stall)
  always_comb begin
    en_raw     = {STAGES{tick}} & ~hold;
    rst_raw    = '0;
    rst_raw[0] = en_raw[0] & ~fetch_raw;
    for (int i = 1; i < STAGES; i++) begin
      rst_raw[i] = en_raw[i] & ~en_raw[i-1];
    end
    if (bus.br_flush) begin
      rst_raw[0] = 1'b1;
    end
    if (bus.exc_flush) begin
      for (int i = 0; i <= EXC_STAGE; i++) begin
        rst_raw[i] = 1'b1;
      end
    end
  end

  // Valid bits: clear on bubble/flush, shift on enable, otherwise hold
  always_comb begin
    valid_d = valid_q;
    if (rst_raw[0]) begin
      valid_d[0] = 1'b0;
    end else if (en_raw[0]) begin
      valid_d[0] = 1'b1;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (rst_raw[i]) begin
        valid_d[i] = 1'b0;
      end else if (en_raw[i]) begin
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  // Mode FSM: drain has priority over debug stepping
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (bus.drain_req)     state_d = ST_DRAIN;
        else if (bus.debug_en) state_d = ST_STEP;
      end
      ST_DRAIN: begin
        if (!bus.drain_req)                                 state_d = ST_RUN;
        else if ((valid_q == '0) && (bus.stall_req == '0))  state_d = ST_HALT;
      end
      ST_HALT: begin
        if (!bus.drain_req) state_d = bus.debug_en ? ST_STEP : ST_RUN;
      end
      ST_STEP: begin
        if (bus.drain_req)      state_d = ST_DRAIN;
        else if (!bus.debug_en) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      valid_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  // While reset is held the datapath sees all stages cleared and frozen
  assign bus.stage_en    = rst ? en_raw : '0;
  assign bus.stage_rst   = rst ? rst_raw : '1;
  assign bus.fetch_en    = rst & fetch_raw;
  assign bus.stage_valid = valid_q;
  assign bus.drained     = (state_q == ST_HALT);
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl: a behavioural model of the five-stage
// configuration checked every cycle, literal expectations for key scenarios,
// and cold-start/flush checks on 2- and 8-stage instances.
module tb_pipe_stage_ctrl;

  localparam int NS  = 5;
  localparam int NX  = 3;
  localparam int NSY = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_ctrl_if #(.STAGES(NS)) bus ();
  pipe_stage_ctrl_if #(.STAGES(2))  bus2 ();
  pipe_stage_ctrl_if #(.STAGES(8))  bus8 ();

  pipe_stage_ctrl #(.STAGES(NS), .EXC_STAGE(NX), .SYNC_STAGES(NSY)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  pipe_stage_ctrl #(.STAGES(2), .EXC_STAGE(0), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));
  pipe_stage_ctrl #(.STAGES(8), .EXC_STAGE(6), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8));

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;
  int cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (5-stage instance) ----------------
  // m_st: 0 run, 1 drain, 2 halt, 3 step
  int            m_st   = 0;
  logic [NS-1:0] m_v    = '0;
  logic          m_pend = 1'b0;
  logic [NSY:0]  m_sh   = '0;   // debug_step samples, [0] newest

  task automatic model_outs(output logic [NS-1:0] en, output logic [NS-1:0] rv,
                            output logic fe, output logic fire, output logic pulse,
                            output int hi);
    logic tk;
    hi = -1;
    for (int j = 0; j < NS; j++) if (bus.stall_req[j]) hi = j;
    pulse = m_sh[NSY-1] & ~m_sh[NSY];
    fire  = (m_st == 3) && (pulse || m_pend) && (hi < 0);
    tk    = (m_st == 0) || (m_st == 1) || fire;
    fe    = ((m_st == 0) || (m_st == 3)) && !bus.drain_req;
    for (int i = 0; i < NS; i++) en[i] = tk && (i > hi);
    rv[0] = en[0] && !fe;
    for (int i = 1; i < NS; i++) rv[i] = tk && (hi >= 0) && (i == hi + 1);
    if (bus.br_flush) rv[0] = 1'b1;
    if (bus.exc_flush) for (int i = 0; i <= NX; i++) rv[i] = 1'b1;
    if (!rst) begin
      en = '0; rv = '1; fe = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    logic [NS-1:0] en, rv, nv;
    logic fe, fire, pulse;
    int hi, nst;
    if (!rst) begin
      m_st = 0; m_v = '0; m_pend = 1'b0; m_sh = '0;
    end else begin
      model_outs(en, rv, fe, fire, pulse, hi);
      for (int i = 0; i < NS; i++) begin
        if (rv[i])      nv[i] = 1'b0;
        else if (en[i]) nv[i] = (i == 0) ? 1'b1 : m_v[i-1];
        else            nv[i] = m_v[i];
      end
      nst = m_st;
      case (m_st)
        0: if (bus.drain_req) nst = 1; else if (bus.debug_en) nst = 3;
        1: if (!bus.drain_req) nst = 0; else if (m_v == 0 && bus.stall_req == 0) nst = 2;
        2: if (!bus.drain_req) nst = bus.debug_en ? 3 : 0;
        default: if (bus.drain_req) nst = 1; else if (!bus.debug_en) nst = 0;
      endcase
      if (m_st != 3)             m_pend = 1'b0;
      else if (fire)             m_pend = 1'b0;
      else if (pulse && hi >= 0) m_pend = 1'b1;
      m_v  = nv;
      m_st = nst;
      m_sh = {m_sh[NSY-1:0], bus.debug_step};
    end
  end

  // Compare every cycle, away from the active edge; also count ticks
  always @(negedge clk) begin
    logic [NS-1:0] en, rv;
    logic fe, fire, pulse;
    int hi;
    #3;
    model_outs(en, rv, fe, fire, pulse, hi);
    chk("stage_en",    32'(bus.stage_en),    32'(en));
    chk("stage_rst",   32'(bus.stage_rst),   32'(rv));
    chk("fetch_en",    32'(bus.fetch_en),    32'(fe));
    chk("stage_valid", 32'(bus.stage_valid), 32'(m_v));
    chk("state",       32'(bus.state),       m_st);
    chk("drained",     32'(bus.drained),     (m_st == 2) ? 1 : 0);
    if (bus.stage_en != '0) tick_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bus.stall_req = '0; bus.exc_flush = 0; bus.br_flush = 0;
    bus.drain_req = 0; bus.debug_en = 0; bus.debug_step = 0;
    bus2.stall_req = '0; bus2.exc_flush = 0; bus2.br_flush = 0;
    bus2.drain_req = 0; bus2.debug_en = 0; bus2.debug_step = 0;
    bus8.stall_req = '0; bus8.exc_flush = 0; bus8.br_flush = 0;
    bus8.drain_req = 0; bus8.debug_en = 0; bus8.debug_step = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #3;
    chk("rst_stage_rst", 32'(bus.stage_rst), 'h1F);
    chk("rst_stage_en",  32'(bus.stage_en), 'h0);
    chk("rst_fetch_en",  32'(bus.fetch_en), 'h0);
    chk("rst_valid",     32'(bus.stage_valid), 'h0);
    chk("rst_drained",   32'(bus.drained), 'h0);

    // Cold start on all three sizes
    @(negedge clk) rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #3;
      chk("cold_valid5", 32'(bus.stage_valid),  (k >= 5) ? 'h1F : ((1 << k) - 1));
      chk("cold_en5",    32'(bus.stage_en),     'h1F);
      chk("cold_valid2", 32'(bus2.stage_valid), (k >= 2) ? 'h3 : ((1 << k) - 1));
      chk("cold_valid8", 32'(bus8.stage_valid), (1 << k) - 1);
    end

    // Mid-pipe stall for 3 cycles
    @(negedge clk) bus.stall_req = 5'b00100;
    #3;
    chk("stall_en",  32'(bus.stage_en),  'h18);
    chk("stall_rst", 32'(bus.stage_rst), 'h08);
    repeat (3) @(negedge clk);
    bus.stall_req = '0;
    #3 chk("stall_valid", 32'(bus.stage_valid), 'h07);
    @(negedge clk); #3 chk("refill1", 32'(bus.stage_valid), 'h0F);
    @(negedge clk); #3 chk("refill2", 32'(bus.stage_valid), 'h1F);

    // Exception with downstream stall; sweep instances flush too
    @(negedge clk);
    bus.exc_flush = 1; bus.stall_req = 5'b10000;
    bus2.exc_flush = 1; bus8.exc_flush = 1;
    #3;
    chk("exc_rst",  32'(bus.stage_rst),  'h0F);
    chk("exc_en",   32'(bus.stage_en),   'h00);
    chk("exc_rst2", 32'(bus2.stage_rst), 'h1);
    chk("exc_rst8", 32'(bus8.stage_rst), 'h7F);
    @(negedge clk);
    bus.exc_flush = 0; bus.stall_req = '0;
    bus2.exc_flush = 0; bus8.exc_flush = 0;
    #3;
    chk("exc_valid",  32'(bus.stage_valid),  'h10);
    chk("exc_valid2", 32'(bus2.stage_valid), 'h2);
    chk("exc_valid8", 32'(bus8.stage_valid), 'h80);
    repeat (6) @(negedge clk);

    // Branch redirect squashes stage 0 only
    bus.br_flush = 1;
    #3 chk("br_rst", 32'(bus.stage_rst), 'h01);
    @(negedge clk) bus.br_flush = 0;
    #3 chk("br_valid", 32'(bus.stage_valid), 'h1E);
    repeat (5) @(negedge clk);

    // Drain with a full pipe
    bus.drain_req = 1;
    #3 chk("drain_fetch", 32'(bus.fetch_en), 'h0);
    cnt = 0;
    do begin
      @(negedge clk); #3; cnt++;
    end while (!bus.drained && cnt < 20);
    chk("drain_cycles", cnt, 6);
    @(negedge clk) bus.drain_req = 0;
    #3 chk("halt_fetch", 32'(bus.fetch_en), 'h0);
    @(negedge clk); #3;
    chk("resume_state", 32'(bus.state), 'h0);
    chk("resume_fetch", 32'(bus.fetch_en), 'h1);

    // Single-step: three pulses, three ticks
    @(negedge clk) bus.debug_en = 1;
    @(negedge clk) tick_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk) bus.debug_step = 1;
      repeat (2) @(negedge clk);
      bus.debug_step = 0;
      repeat (18) @(negedge clk);
    end
    #4 chk("step_ticks", tick_cnt, 3);

    // Step during stall: held as pending, second pulse dropped
    @(negedge clk);
    bus.stall_req = 5'b00001; tick_cnt = 0; bus.debug_step = 1;
    repeat (2) @(negedge clk);
    bus.debug_step = 0;
    repeat (8) @(negedge clk);
    #4 chk("stall_step_none", tick_cnt, 0);
    @(negedge clk) bus.debug_step = 1;
    repeat (2) @(negedge clk);
    bus.debug_step = 0;
    repeat (8) @(negedge clk);
    bus.stall_req = '0;
    repeat (10) @(negedge clk);
    #4 chk("stall_step_one", tick_cnt, 1);

    @(negedge clk) bus.debug_en = 0;
    @(negedge clk); #3 chk("step_exit", 32'(bus.state), 'h0);
    repeat (6) @(negedge clk);

    // Exception while draining stays in drain
    bus.drain_req = 1;
    repeat (2) @(negedge clk);
    bus.exc_flush = 1;
    @(negedge clk) bus.exc_flush = 0;
    #3 chk("drain_exc_state", 32'(bus.state), 'h1);
    cnt = 0;
    do begin
      @(negedge clk); #3; cnt++;
    end while (!bus.drained && cnt < 20);
    chk("drain_exc_halt", 32'(bus.drained), 'h1);
    @(negedge clk) bus.drain_req = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
